// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    localparam int unsigned DEF_N_DIG     = 3;
    localparam int unsigned DEF_PRESC_W   = 16;
    localparam int unsigned DEF_PRESC_DIV = 10000;
    localparam int unsigned DEF_BLANK_CYC = 8;

    // Glyphs as {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to seven-segment glyph decoder.
module seg7_hex_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_0;
        case (nib)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_0;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blank gaps and frame-aligned
// double-buffered updates. Optional brightness gating via DISP_DIM_EN.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned N_DIG     = DEF_N_DIG,
    parameter int unsigned PRESC_W   = DEF_PRESC_W,
    parameter int unsigned PRESC_DIV = DEF_PRESC_DIV,
    parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DISP_DIM_EN
    input  logic [3:0]           bright,
`endif
    input  logic                 upd_valid,
    input  logic [4*N_DIG-1:0]   upd_data,
    output logic                 upd_ready,
    output logic [N_DIG-1:0]     transistor,
    output logic [6:0]           d7sp,
    output logic                 frame_tick
);

    localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int unsigned DAT_W = 4 * N_DIG;
    localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'(BLANK_CYC - 1);
    localparam logic [PRESC_W-1:0] ON_LAST    = PRESC_W'(PRESC_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIG - 1);

    state_e             state, state_n;
    logic [PRESC_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [DAT_W-1:0]   active, active_n, shadow, shadow_n;
    logic               pend, pend_n;
    logic               boundary, xfer, commit;
    logic [3:0]         nib;
    logic [6:0]         seg_dec;
    logic [N_DIG-1:0]   transistor_n;
    logic [6:0]         d7sp_n;
    logic               frame_tick_n, upd_ready_n;
`ifdef DISP_DIM_EN
    logic [3:0]         sub, sub_n;
`endif

    seg7_hex_dec u_dec (
        .nib   (nib),
        .seg_c (seg_dec)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pend       <= 1'b0;
            transistor <= '0;
            d7sp       <= '0;
            frame_tick <= 1'b0;
            upd_ready  <= 1'b1;
`ifdef DISP_DIM_EN
            sub        <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            active     <= active_n;
            shadow     <= shadow_n;
            pend       <= pend_n;
            transistor <= transistor_n;
            d7sp       <= d7sp_n;
            frame_tick <= frame_tick_n;
            upd_ready  <= upd_ready_n;
`ifdef DISP_DIM_EN
            sub        <= sub_n;
`endif
        end
    end

    // Scan sequencing and shadow/active buffer next values
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + PRESC_W'(1);
        idx_n    = idx;
        boundary = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_ON;
                    cnt_n   = '0;
                end
            end
            ST_ON: begin
                if (cnt == ON_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    if (idx == IDX_LAST) begin
                        idx_n    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = ST_BLANK;
        endcase

        xfer     = upd_valid && upd_ready;
        commit   = boundary && pend;
        active_n = commit ? shadow : active;
        shadow_n = xfer ? upd_data : shadow;
        pend_n   = commit ? 1'b0 : (xfer ? 1'b1 : pend);

        nib = '0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (idx_n == IDX_W'(i)) nib = active_n[4*i +: 4];
        end
    end

    // Registered output values; segments only change on entry to or within BLANK
    always_comb begin
        transistor_n = '0;
        d7sp_n       = d7sp;
        frame_tick_n = boundary;
        upd_ready_n  = !pend_n;
`ifdef DISP_DIM_EN
        sub_n = (state == ST_BLANK && state_n == ST_ON) ? 4'd0 : sub + 4'd1;
        if (state_n == ST_ON && sub_n <= bright) transistor_n = N_DIG'(1) << idx_n;
`else
        if (state_n == ST_ON) transistor_n = N_DIG'(1) << idx_n;
`endif
        if (state_n == ST_BLANK) d7sp_n = seg_dec;
    end

endmodule
